// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word size, channel encoding and the stereo frame type.
// Used by the transmitter and the receiver.
package i2s_pkg;

    localparam int I2S_WORD_SIZE = 32;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    typedef struct packed {
        logic [I2S_WORD_SIZE-1:0] left;
        logic [I2S_WORD_SIZE-1:0] right;
    } stereo_frame_t;

    // Bit of a flattened {left, right} frame that is on the wire in slot k:
    // slot 0 carries the previous right LSB, slots 1.. walk down from the left MSB.
    function automatic int frame_bit_idx(input int k, input int word_size);
        return (k == 0) ? 0 : 2 * word_size - k;
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-side handshake of the I2S transmitter: one stereo frame offered with valid/ready.
interface i2s_tx_if
    import i2s_pkg::*;
#(
    parameter int WORD_SIZE = I2S_WORD_SIZE
);

    logic [WORD_SIZE-1:0] l_din;
    logic [WORD_SIZE-1:0] r_din;
    logic                 din_valid;
    logic                 din_ready;

    modport master (output l_din, output r_din, output din_valid, input din_ready);
    modport slave  (input l_din, input r_din, input din_valid, output din_ready);

endinterface

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides clk into a 50% duty bck and flags the clk cycle
// in which bck is about to fall or rise.
module i2s_clkgen #(
    parameter int BCK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic bck_o,
    output logic fall_tick_o,
    output logic rise_tick_o
);

    localparam int               CTR_W    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(BCK_DIV - 1);

    logic [CTR_W-1:0] div_ctr_q, div_ctr_d;
    logic             bck_q, bck_d;
    logic             terminal;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        terminal  = (div_ctr_q == CTR_LAST);
        div_ctr_d = terminal ? '0 : div_ctr_q + CTR_W'(1);
        bck_d     = terminal ? ~bck_q : bck_q;
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_ctr_q <= '0;
            bck_q     <= 1'b0;
        end else begin
            div_ctr_q <= div_ctr_d;
            bck_q     <= bck_d;
        end
    end

    assign bck_o       = bck_q;
    assign fall_tick_o = terminal & bck_q;
    assign rise_tick_o = terminal & ~bck_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter (Philips format) with a single-entry frame buffer.
// Build option I2S_TX_HOLD_ON_UNDERRUN_EN: repeat the last frame on underrun instead of sending zeros.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int WORD_SIZE = I2S_WORD_SIZE,
    parameter int BCK_DIV   = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    i2s_tx_if.slave din_if,
    output logic    bck_o,
    output logic    lrck_o,
    output logic    dout_o,
    output logic    underrun_o
);

    localparam int               FRAME_BITS = 2 * WORD_SIZE;
    localparam int               CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_BITS - 1);

    typedef struct packed {
        logic [WORD_SIZE-1:0] left;
        logic [WORD_SIZE-1:0] right;
    } frame_t;

    logic fall_tick;
    logic rise_tick_unused;

    i2s_clkgen #(.BCK_DIV(BCK_DIV)) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .bck_o       (bck_o),
        .fall_tick_o (fall_tick),
        .rise_tick_o (rise_tick_unused)
    );

    logic [CNT_W-1:0]      bit_ctr_q, bit_ctr_d;
    logic                  lrck_q, lrck_d;
    logic                  dout_q, dout_d;
    logic                  din_ready_q, din_ready_d;
    logic                  underrun_q, underrun_d;
    frame_t                active_q, active_d;
    frame_t                pending_q, pending_d;
    logic                  load;
    logic                  accept;
    logic [CNT_W-1:0]      bit_idx;
    logic [FRAME_BITS-1:0] frame_bits;

    always_comb begin
        load        = fall_tick && (bit_ctr_q == '0);
        accept      = din_if.din_valid && din_ready_q;
        bit_ctr_d   = bit_ctr_q;
        lrck_d      = lrck_q;
        dout_d      = dout_q;
        din_ready_d = din_ready_q;
        underrun_d  = 1'b0;
        active_d    = active_q;
        pending_d   = pending_q;
        bit_idx     = '0;
        frame_bits  = '0;

        // din_ready is low whenever pending is full, so accept and load never contend.
        if (accept) begin
            pending_d.left  = din_if.l_din;
            pending_d.right = din_if.r_din;
            din_ready_d     = 1'b0;
        end

        if (fall_tick) begin
            bit_ctr_d = (bit_ctr_q == CNT_LAST) ? '0 : bit_ctr_q + CNT_W'(1);
            if (load) begin
                if (!din_ready_q) begin
                    active_d    = pending_q;
                    din_ready_d = 1'b1;
                end else begin
                    underrun_d = 1'b1;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
                    active_d   = active_q;
`else
                    active_d   = '0;
`endif
                end
            end
            lrck_d     = (bit_ctr_d >= CNT_W'(WORD_SIZE)) ? LRCK_RIGHT : LRCK_LEFT;
            bit_idx    = CNT_W'(frame_bit_idx(int'(bit_ctr_d), WORD_SIZE));
            frame_bits = active_d;
            dout_d     = frame_bits[bit_idx];
        end
    end

    // NOTE: the frame registers are reset too: a reset must discard queued audio, not replay it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_ctr_q   <= CNT_LAST;
            lrck_q      <= LRCK_RIGHT;
            dout_q      <= 1'b0;
            din_ready_q <= 1'b1;
            underrun_q  <= 1'b0;
            active_q    <= '0;
            pending_q   <= '0;
        end else begin
            bit_ctr_q   <= bit_ctr_d;
            lrck_q      <= lrck_d;
            dout_q      <= dout_d;
            din_ready_q <= din_ready_d;
            underrun_q  <= underrun_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
        end
    end

    assign lrck_o           = lrck_q;
    assign dout_o           = dout_q;
    assign underrun_o       = underrun_q;
    assign din_if.din_ready = din_ready_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: expected serial slots are queued by the stimulus and
// popped by a monitor on every bck rising edge; two extra instances check bck/lrck timing.
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int W   = 8;
    localparam int DIV = 2;
    localparam int WE  = 16;
    localparam int E_DIV [2] = '{1, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_e_n;

    i2s_tx_if #(.WORD_SIZE(W)) a_if ();
    logic a_bck, a_lrck, a_dout, a_under;

    i2s_tx #(.WORD_SIZE(W), .BCK_DIV(DIV)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_if     (a_if),
        .bck_o      (a_bck),
        .lrck_o     (a_lrck),
        .dout_o     (a_dout),
        .underrun_o (a_under)
    );

    i2s_tx_if #(.WORD_SIZE(WE)) e0_if ();
    i2s_tx_if #(.WORD_SIZE(WE)) e1_if ();
    logic [1:0] e_bck, e_lrck, e_dout, e_underrun_unused;

    i2s_tx #(.WORD_SIZE(WE), .BCK_DIV(1)) dut_e0 (
        .clk        (clk),
        .rst_n      (rst_e_n),
        .din_if     (e0_if),
        .bck_o      (e_bck[0]),
        .lrck_o     (e_lrck[0]),
        .dout_o     (e_dout[0]),
        .underrun_o (e_underrun_unused[0])
    );

    i2s_tx #(.WORD_SIZE(WE), .BCK_DIV(5)) dut_e1 (
        .clk        (clk),
        .rst_n      (rst_e_n),
        .din_if     (e1_if),
        .bck_o      (e_bck[1]),
        .lrck_o     (e_lrck[1]),
        .dout_o     (e_dout[1]),
        .underrun_o (e_underrun_unused[1])
    );

    typedef struct packed {
        logic lrck;
        logic dout;
    } slot_t;

    slot_t exp_q[$];
    logic  last_r0;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_idle_slot();
        slot_t s;
        s.lrck = 1'b1;
        s.dout = 1'b0;
        exp_q.push_back(s);
    endtask

    // One frame of slots: slot 0 is the previous right LSB, then left MSB..LSB, then right MSB..bit 1.
    task automatic push_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        slot_t s;
        for (int k = 0; k < 2 * W; k++) begin
            s.lrck = (k >= W);
            if (k == 0)      s.dout = last_r0;
            else if (k <= W) s.dout = l[W-k];
            else             s.dout = r[2*W-k];
            exp_q.push_back(s);
        end
        last_r0 = r[0];
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input bit push);
        int n = 0;
        if (push) push_frame(l, r);
        @(negedge clk);
        a_if.l_din     = l;
        a_if.r_din     = r;
        a_if.din_valid = 1'b1;
        while (!a_if.din_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", a_if.din_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        last_r0 = 1'b0;
        push_idle_slot();
    endtask

    // Main monitor: compare one queued slot per bck rising edge, count underrun and ready edges.
    logic prev_bck, prev_under, prev_ready;
    int   under_pulses = 0;
    int   under_hi     = 0;
    int   ready_rises  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_bck   <= 1'b0;
            prev_under <= 1'b0;
            prev_ready <= 1'b1;
        end else begin
            if (a_bck && !prev_bck && exp_q.size() > 0) begin
                check("dout", a_dout, exp_q[0].dout);
                check("lrck", a_lrck, exp_q[0].lrck);
                void'(exp_q.pop_front());
            end
            if (a_under)                     under_hi     <= under_hi + 1;
            if (a_under && !prev_under)      under_pulses <= under_pulses + 1;
            if (a_if.din_ready && !prev_ready) ready_rises <= ready_rises + 1;
            prev_bck   <= a_bck;
            prev_under <= a_under;
            prev_ready <= a_if.din_ready;
        end
    end

    // Timing monitor for the WE=16 instances.
    int         e_cyc = 0;
    int         e_last_rise [2] = '{-1, -1};
    int         e_rises [2]     = '{0, 0};
    int         e_last_lrck [2] = '{-1, -1};
    int         e_lrck_meas [2] = '{0, 0};
    logic [1:0] e_prev_bck, e_prev_lrck, e_prev_dout;

    always @(negedge clk) begin
        if (!rst_e_n) begin
            e_prev_bck  <= e_bck;
            e_prev_lrck <= e_lrck;
            e_prev_dout <= e_dout;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (e_bck[i] && !e_prev_bck[i]) begin
                    if (e_last_rise[i] >= 0)
                        check("e_bck_period", e_cyc - e_last_rise[i], 2 * E_DIV[i]);
                    e_last_rise[i] <= e_cyc;
                    e_rises[i]     <= e_rises[i] + 1;
                end
                if ((e_lrck[i] != e_prev_lrck[i]) || (e_dout[i] != e_prev_dout[i]))
                    check("e_change_on_fall", {e_prev_bck[i], e_bck[i]}, 2'b10);
                if (e_lrck[i] && !e_prev_lrck[i]) begin
                    if (e_last_lrck[i] >= 0) begin
                        check("e_lrck_period", e_rises[i] - e_last_lrck[i], 2 * WE);
                        e_lrck_meas[i] <= e_lrck_meas[i] + 1;
                    end
                    e_last_lrck[i] <= e_rises[i];
                end
            end
            e_prev_bck  <= e_bck;
            e_prev_lrck <= e_lrck;
            e_prev_dout <= e_dout;
            e_cyc       <= e_cyc + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n           = 1'b0;
        rst_e_n         = 1'b0;
        last_r0         = 1'b0;
        a_if.din_valid  = 1'b0;
        a_if.l_din      = '0;
        a_if.r_din      = '0;
        e0_if.din_valid = 1'b1;
        e0_if.l_din     = 16'hA5C3;
        e0_if.r_din     = 16'h3C5A;
        e1_if.din_valid = 1'b1;
        e1_if.l_din     = 16'h8001;
        e1_if.r_din     = 16'h7FFE;

        repeat (2) @(negedge clk);
        check("rst_bck", a_bck, 1'b0);
        check("rst_lrck", a_lrck, 1'b1);
        check("rst_dout", a_dout, 1'b0);
        check("rst_ready", a_if.din_ready, 1'b1);
        check("rst_underrun", a_under, 1'b0);
        rst_e_n = 1'b1;
        rst_n   = 1'b1;
        push_idle_slot();

        // Known frame, then back-to-back incrementing frames, then starvation.
        send(8'hA5, 8'h3C, 1'b1);
        send(8'h01, 8'h81, 1'b1);
        send(8'h02, 8'h82, 1'b1);
        send(8'hFF, 8'h00, 1'b1);
        @(negedge clk);
        a_if.din_valid = 1'b0;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
        push_frame(8'hFF, 8'h00);
`else
        push_frame(8'h00, 8'h00);
`endif
        wait_drain();
        check("underrun_pulses_a", under_pulses, 1);
        check("underrun_width_a", under_hi, 1);
        check("ready_rises_a", ready_rises, 4);

        // Reset in the middle of a right word while a second frame sits in pending.
        do_reset();
        send(8'h00, 8'hFF, 1'b1);
        send(8'h11, 8'h22, 1'b0);
        @(negedge clk);
        a_if.din_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("pre_rst_dout", a_dout, 1'b1);
        check("pre_rst_lrck", a_lrck, 1'b1);
        check("pre_rst_ready", a_if.din_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_bck", a_bck, 1'b0);
        check("async_lrck", a_lrck, 1'b1);
        check("async_dout", a_dout, 1'b0);
        check("async_ready", a_if.din_ready, 1'b1);
        check("async_underrun", a_under, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        last_r0 = 1'b0;
        push_idle_slot();

        // Restart from slot 0 with nothing pending; offer a frame exactly in the load-point cycle.
        push_frame(8'h00, 8'h00);
        push_frame(8'h5A, 8'hC3);
        repeat (4 * DIV - 1) @(negedge clk);
        a_if.l_din     = 8'h5A;
        a_if.r_din     = 8'hC3;
        a_if.din_valid = 1'b1;
        @(negedge clk);
        a_if.din_valid = 1'b0;
        check("accept_at_load_ready", a_if.din_ready, 1'b0);
        wait_drain();
        check("underrun_pulses_d", under_pulses, 2);
        check("underrun_width_d", under_hi, 2);

        repeat (300) @(negedge clk);
        check("e0_lrck_measured", e_lrck_meas[0] > 0, 1'b1);
        check("e1_lrck_measured", e_lrck_meas[1] > 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter, the counterpart to the team's I2S receiver.
- Runs from one system clock and divides it down to generate bck and lrck.
- Serialises stereo sample pairs onto dout in standard Philips I2S format: MSB first, one-bck delay after each lrck edge, data changing on bck falling edges.
- Feeds a DAC or loopback receiver. Samples are accepted through a single-entry valid/ready frame buffer.

Parameters:
- WORD_SIZE, 32, bits per channel word; frame is 2*WORD_SIZE bck cycles; legal range 8..32.
- BCK_DIV, 4, clk cycles per bck half-period; legal range >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- l_din  in  WORD_SIZE  left sample, two's complement
- r_din  in  WORD_SIZE  right sample
- din_valid  in  1  l_din/r_din hold a frame
- din_ready  out  1  pending buffer empty; transfer when din_valid & din_ready at a clk edge
- bck  out  1  bit clock, 50% duty
- lrck  out  1  word select; 0 = left, 1 = right
- dout  out  1  serial data
- underrun  out  1  one-clk pulse when a frame starts with no pending data

Behaviour:
- Reset (async assert, sync-safe release): bck=0, lrck=1, dout=0, din_ready=1, underrun=0, div_ctr=0, bit_ctr=2*WORD_SIZE-1, pending and active registers cleared.
- Reset mid-operation discards all frames immediately. The first falling edge after release starts a frame.
- Divider: div_ctr counts 0..BCK_DIV-1. At terminal count bck toggles and div_ctr wraps.
- fall_tick: the clk cycle in which bck goes 1->0. All of lrck, dout and bit_ctr update only on fall_tick; they are registered and change on the same clk edge as bck.
- bit_ctr: on fall_tick, wraps 2*WORD_SIZE-1 -> 0, otherwise increments.
- lrck after update: 0 for bit_ctr 0..WORD_SIZE-1, 1 for WORD_SIZE..2*WORD_SIZE-1.
- dout after update, with k = new bit_ctr:
  - k=0: active R[0], the LSB of the previous frame.
  - k=1..WORD_SIZE: active L[WORD_SIZE-k].
  - k=WORD_SIZE+1..2*WORD_SIZE-1: active R[2*WORD_SIZE-k].
- Load point: the fall_tick where bit_ctr goes 0->1.
  - Pending full: active <= pending, pending emptied, din_ready=1 next cycle. dout at this tick already uses the newly loaded L[WORD_SIZE-1], so the load is a bypass into the output mux.
  - Pending empty: underrun pulses for exactly one clk; active follows the underrun policy (Optional Feature).
- Accept: on din_valid & din_ready, pending <= {l_din, r_din} and din_ready <= 0.
  - din_ready is registered, so no accept is possible in the cycle pending is consumed.
  - An accept coinciding with the load point is loaded at the next frame, not this one.
- Back-to-back: a source holding din_valid high sustains one frame per 2*WORD_SIZE bck periods with no underrun after the first.
- Throughput: 2*WORD_SIZE*2*BCK_DIV clk cycles per frame.

Optional Feature:
- Macro: I2S_TX_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun, active keeps its previous contents, so the last frame repeats (zeros if none since reset).
- Undefined: on underrun, active is cleared, so the frame transmits all zeros.
- underrun pulses in both builds.

Decomposition:
- Package i2s_pkg:
  - default WORD_SIZE
  - channel encoding constants LRCK_LEFT=0, LRCK_RIGHT=1
  - a stereo frame typedef {left, right}, shared with the receiver.
- Sub-module i2s_clkgen:
  - takes clk and rst_n, parameter BCK_DIV.
  - outputs bck, fall_tick and rise_tick.
  - reusable for a future master receiver.

Test Plan:
- WORD_SIZE=8, BCK_DIV=2, frame L=0xA5, R=0x3C presented before the first load:
  - dout sampled on bck rising edges, counts 1..8 -> 1,0,1,0,0,1,0,1 with lrck=0.
  - Counts 9..15 -> 0,0,1,1,1,1,0 with lrck=1.
  - Next count 0 -> 0 with lrck=0.
  - No underrun.
- din_valid held high with incrementing frames (0x01/0x81, 0x02/0x82, ...) -> each appears in order on consecutive frames; din_ready pulses high once per frame; underrun never asserts.
- No data after the first frame (0xFF/0x00):
  - Default build: the second frame is all zeros and underrun pulses once at its load point.
  - With I2S_TX_HOLD_ON_UNDERRUN_EN: 0xFF/0x00 repeats.
- rst_n pulsed low mid-right-word:
  - bck=0, lrck=1, dout=0, din_ready=1 asynchronously, before the next clk edge.
  - After release, the frame restarts from count 0 and the old pending frame is never transmitted.
- BCK_DIV=1 and BCK_DIV=5, WORD_SIZE=16:
  - bck period is 2 and 10 clk respectively.
  - lrck period is 32 bck.
  - lrck and dout change only coincident with bck falling edges.
- din_valid asserted exactly in the load-point clk cycle -> the frame is accepted that cycle, the current frame is unaffected or underruns, and the new frame appears at the following frame.
